pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline-stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one reusable block.
- Carries a control bundle and a datapath bundle, with per-entry valid, stall back-pressure via a 2-entry skid buffer, and synchronous flush.
- When no valid entry is presented, control outputs are forced to zero so a bubble can never assert RegWrite, MemWrite, Branch or Jump downstream.

Parameters:
- CTRL_W, 12: width of the control bundle; cleared on flush and masked to zero on bubbles.
- DATA_W, 165: width of the datapath bundle (operands, PC, register indices, immediate, PC+4).
- CLEAR_DATA, 0: 1 = flush and reset also zero the stored data; 0 = data regs hold their values on flush.
- CNT_W, 16: width of the performance counters (used only with the optional feature).

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- FlushIn  in  1  synchronous flush of all held entries
- ValidIn  in  1  upstream entry valid
- ReadyOut  out  1  stage can accept an entry this cycle
- CtrlIn  in  CTRL_W  upstream control bundle
- DataIn  in  DATA_W  upstream datapath bundle
- ValidOut  out  1  head entry valid
- ReadyIn  in  1  downstream accepts the head entry this cycle
- CtrlOut  out  CTRL_W  head control; all zero when ValidOut=0
- DataOut  out  DATA_W  head datapath bundle
- StallCntOut  out  CNT_W  cycles with ValidOut=1 and ReadyIn=0 (only with the optional feature)
- FlushCntOut  out  CNT_W  count of valid entries discarded by flush (only with the optional feature)

Behaviour:
- Storage: main entry M (drives the outputs) and skid entry S, each with its own valid bit. Entries leave in arrival order.
- Handshake:
  - Accept occurs when ValidIn=1 and ReadyOut=1.
  - Drain occurs when ValidOut=1 and ReadyIn=1.
  - CtrlIn and DataIn are sampled only on accept.
- ReadyOut = ~S.valid. It is driven directly from a flop, with no combinational path from ReadyIn.
- ValidOut = M.valid. CtrlOut = M.valid ? M.ctrl : 0. DataOut = M.data in every cycle.
- State machine (encoded as {S.valid, M.valid}):
  - EMPTY: accept loads M and moves to ONE.
  - ONE:
    - Accept and drain together: M loads the new entry; stay in ONE.
    - Drain only: move to EMPTY.
    - Accept only: new entry goes to S; move to FULL.
  - FULL:
    - Drain: S moves into M and S clears; move to ONE.
    - No drain: hold.
    - No accept can occur because ReadyOut=0.
- Latency: 1 cycle from accept to ValidOut when the stage is empty. Throughput is 1 entry per cycle while ReadyIn=1.
- Flush:
  - FlushIn=1 clears M.valid, S.valid and both ctrl fields to 0 at the next edge.
  - Flush has priority over an accept in the same cycle; that input entry is dropped.
  - A drain in the flush cycle still completes. The downstream stage sees the entry; flush removes only what is held after the edge.
  - Data fields are zeroed only when CLEAR_DATA=1.
- Reset:
  - RST=1 forces EMPTY: ValidOut=0, CtrlOut=0, ReadyOut=1 from the next edge onward, and counters at 0.
  - DataOut=0 when CLEAR_DATA=1; otherwise it is undefined until the first accept.
  - RST has priority over FlushIn and over any handshake.
  - RST asserted mid-stream discards all held entries; no partial state survives.
- ReadyIn=0 with EMPTY is legal and has no effect.
- ValidIn=1 while ReadyOut=0 is not an accept. Upstream must hold the entry stable until it is accepted.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - StallCntOut increments by 1 each cycle with ValidOut=1 and ReadyIn=0.
  - FlushCntOut increments by M.valid+S.valid on each flush cycle in which RST=0.
  - Both counters saturate at all-ones and reset to 0.
- Undefined:
  - Both ports and all counter logic are absent.
  - Handshake and flush behaviour is identical to the defined build.

Test Plan:
- Reset then idle: RST=1 for 2 cycles with ValidIn=1 → ValidOut=0, CtrlOut=0, ReadyOut=1. After release with ValidIn=0, the state stays EMPTY.
- Streaming: ReadyIn=1, ValidIn=1 with DataIn=1,2,3,4 on consecutive cycles → DataOut=1,2,3,4 one cycle later each; ReadyOut stays 1.
- Back-pressure: ReadyIn=0; push A=0xA then B=0xB.
  - After B, ReadyOut=0; a third entry C=0xC is held upstream.
  - Then ReadyIn=1 → outputs A, B, C in order, with no loss or duplicate.
- Flush priority: in FULL with A and B held, assert FlushIn=1 together with ValidIn=1 (C=0xC) and ReadyIn=0.
  - Next cycle: ValidOut=0, CtrlOut=0, ReadyOut=1; C is never output.
  - With CLEAR_DATA=1, DataOut=0.
- Bubble masking: push CtrlIn=0xFFF, drain it, then leave ValidIn=0 → CtrlOut=0x000 while DataOut holds its last value (CLEAR_DATA=0).
- Perf counters (PIPE_STAGE_PERF_EN defined, CNT_W=2): 5 stall cycles → StallCntOut=3 (saturated). A flush in FULL → FlushCntOut=2.

Source files
------------

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg : handshaked pipeline-stage register with 2-entry skid buffer,
//                  synchronous flush and bubble control masking.
// Optional perf counters when PIPE_STAGE_PERF_EN is defined.
// Revision: 1.0
// ============================================================================
module pipe_stage_reg #(
  parameter int CTRL_W     = 12,
  parameter int DATA_W     = 165,
  parameter int CLEAR_DATA = 0
`ifdef PIPE_STAGE_PERF_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FlushIn,
  input  logic              ValidIn,
  output logic              ReadyOut,
  input  logic [CTRL_W-1:0] CtrlIn,
  input  logic [DATA_W-1:0] DataIn,
  output logic              ValidOut,
  input  logic              ReadyIn,
  output logic [CTRL_W-1:0] CtrlOut,
  output logic [DATA_W-1:0] DataOut
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] StallCntOut
  , output logic [CNT_W-1:0] FlushCntOut
`endif
);

  // Encoding is {S.valid, M.valid}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic [DATA_W-1:0] r_s_data;
  logic              w_accept;
  logic              w_drain;
  logic              w_load_m_in;
  logic              w_load_m_skid;
  logic              w_load_s;

  assign w_accept = ValidIn & ~r_state[1];
  assign w_drain  = r_state[0] & ReadyIn;

  always_comb begin
    w_state_nxt   = r_state;
    w_load_m_in   = 1'b0;
    w_load_m_skid = 1'b0;
    w_load_s      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_load_m_in = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          w_load_m_in = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
          w_load_s    = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_drain) begin
          w_load_m_skid = 1'b1;
          w_state_nxt   = ST_ONE;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush wins over any accept; a concurrent drain needs no local action.
    if (FlushIn) begin
      w_state_nxt   = ST_EMPTY;
      w_load_m_in   = 1'b0;
      w_load_m_skid = 1'b0;
      w_load_s      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || FlushIn) begin
      r_m_ctrl <= '0;
      r_s_ctrl <= '0;
    end else begin
      if (w_load_m_in) begin
        r_m_ctrl <= CtrlIn;
      end else if (w_load_m_skid) begin
        r_m_ctrl <= r_s_ctrl;
      end
      if (w_load_s) begin
        r_s_ctrl <= CtrlIn;
      end
    end
  end

  // Data regs are only cleared when CLEAR_DATA is set; otherwise they hold.
  always_ff @(posedge CLK) begin
    if (RST || FlushIn) begin
      if (CLEAR_DATA != 0) begin
        r_m_data <= '0;
        r_s_data <= '0;
      end
    end else begin
      if (w_load_m_in) begin
        r_m_data <= DataIn;
      end else if (w_load_m_skid) begin
        r_m_data <= r_s_data;
      end
      if (w_load_s) begin
        r_s_data <= DataIn;
      end
    end
  end

  assign ReadyOut = ~r_state[1];
  assign ValidOut = r_state[0];
  assign CtrlOut  = r_state[0] ? r_m_ctrl : '0;
  assign DataOut  = r_m_data;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [1:0]       w_held;
  logic [CNT_W:0]   w_flush_sum;

  assign w_held      = {1'b0, r_state[0]} + {1'b0, r_state[1]};
  assign w_flush_sum = {1'b0, r_flush_cnt} + (CNT_W+1)'(w_held);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_state[0] && !ReadyIn && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (FlushIn) begin
        r_flush_cnt <= w_flush_sum[CNT_W] ? '1 : w_flush_sum[CNT_W-1:0];
      end
    end
  end

  assign StallCntOut = r_stall_cnt;
  assign FlushCntOut = r_flush_cnt;
`endif

endmodule
`default_nettype wire
